// File: rtl/fp_operand_pipe.sv
// fp_operand_pipe: elastic DEPTH-stage register for packed floating-point
// operand bundles (NOPS x {sign, EW-bit exponent, MW-bit mantissa}).
// Valid/ready handshake with bubble collapsing, synchronous flush and a
// registered occupancy count. Operand fields are carried as opaque bits.
module fp_operand_pipe #(
    parameter int NOPS  = 2,
    parameter int EW    = 8,
    parameter int MW    = 24,
    parameter int DEPTH = 1
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         FLUSH,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [NOPS-1:0]              IN_SIGN,
    input  logic [NOPS*EW-1:0]           IN_EXP,
    input  logic [NOPS*MW-1:0]           IN_MANT,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [NOPS-1:0]              OUT_SIGN,
    output logic [NOPS*EW-1:0]           OUT_EXP,
    output logic [NOPS*MW-1:0]           OUT_MANT,
    output logic [$clog2(DEPTH+1)-1:0]   OCC
);

    // One bundle = all signs, then all exponents, then all mantissas.
    localparam int BW = NOPS * (1 + EW + MW);
    localparam int OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_q, v_d;
    logic [BW-1:0]    d_q [DEPTH];
    logic [BW-1:0]    d_d [DEPTH];
    logic [OW-1:0]    occ_q, occ_d;

    // Per-stage ready, and what each stage would load from upstream.
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] up_v;
    logic [BW-1:0]    up_d [DEPTH];

    logic in_xfer;
    logic out_xfer;

    assign up_v[0] = IN_VALID;
    assign up_d[0] = {IN_SIGN, IN_EXP, IN_MANT};

    // Stage i may advance when it is empty, or any stage downstream of it
    // is empty, or the consumer takes the head bundle. Written as a
    // reduction over v_q so the chain is a pure function of state plus
    // OUT_READY (the only combinational input-to-output path).
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rdy
        assign rdy[gi] = OUT_READY | ~(&v_q[DEPTH-1:gi]);
    end

    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_up
        assign up_v[gi] = v_q[gi-1];
        assign up_d[gi] = d_q[gi-1];
    end

    assign IN_READY = rdy[0];
    assign in_xfer  = IN_VALID & rdy[0];
    assign out_xfer = v_q[DEPTH-1] & OUT_READY;

    // Next-state for stage valids and data; flush clears valids only.
    always_comb begin
        // NOTE: every always_comb output gets a full default first, so no path leaves it unassigned and no latch is inferred.
        v_d = v_q;
        d_d = d_q;
        if (FLUSH) begin
            v_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v_d[i] = up_v[i];
                    // Data only moves with a valid bundle; bubbles leave it alone.
                    if (up_v[i]) begin
                        d_d[i] = up_d[i];
                    end
                end
            end
        end
    end

    // Occupancy tracks transfers; simultaneous in and out cancel.
    always_comb begin
        occ_d = occ_q;
        if (FLUSH) begin
            occ_d = '0;
        end else if (in_xfer && !out_xfer) begin
            occ_d = occ_q + OW'(1);
        end else if (out_xfer && !in_xfer) begin
            occ_d = occ_q - OW'(1);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            v_q   <= '0;
            occ_q <= '0;
            // NOTE: stage data is cleared on reset so the outputs read zero while empty; this register array is small enough to be flops, not RAM.
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments here so every stage samples the pre-edge value of its neighbour.
            v_q   <= v_d;
            occ_q <= occ_d;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

    assign OUT_VALID                     = v_q[DEPTH-1];
    assign {OUT_SIGN, OUT_EXP, OUT_MANT} = d_q[DEPTH-1];
    assign OCC                           = occ_q;

endmodule
